// File: rtl/adder_pkg.sv
// adder_pkg: shared helpers and stage-payload types for pipelined_adder.
//   slice_w(width, stages) : bits handled per pipeline slice.
//   stage_ctl_t            : per-op control bits travelling with each stage payload.
package adder_pkg;

  // Bits per slice; a zero stage count is rejected at elaboration by the top.
  function automatic int unsigned slice_w(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  typedef struct packed {
    logic valid;  // stage holds a live op
    logic sub;    // op is A-B
    logic sat;    // saturate on overflow/borrow
    logic carry;  // carry into the next slice (carry out of the MSB slice at the end)
  } stage_ctl_t;

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit adder with carry in/out, one per pipeline stage.
//   a, b : slice operands (b already inverted for subtraction)
//   cin  : carry in
//   sum  : slice sum
//   cout : carry out
module adder_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] total_c;

  assign total_c = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
  assign sum     = total_c[W-1:0];
  assign cout    = total_c[W];

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: pipelined WIDTH-bit add/subtract unit, carry chain split into
// STAGES registered slices, valid/ready on both sides, one op per cycle.
//   clk, rst (async, active-high)
//   in_valid/in_ready, in_a, in_b, in_sub (0: A+B, 1: A+~B+1), in_sat (ADDER_SAT_EN only)
//   out_valid/out_ready, out_sum, out_carry (sub: 1 = no borrow)
// Optional feature macro: ADDER_SAT_EN (saturating results, adds in_sat port).
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
`ifdef ADDER_SAT_EN
  input  logic             in_sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

  localparam int unsigned SW = slice_w(WIDTH, STAGES);

  if (STAGES == 0 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Operands ride along with their op so each slice sees its own upper bits.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } payload_t;

  payload_t stage_q [STAGES];
  payload_t stage_d [STAGES];
  payload_t in_pl;
  logic     adv;

  // Whole pipe moves together: advance unless the result is blocked.
  assign adv      = out_ready | ~stage_q[STAGES-1].ctl.valid;
  assign in_ready = adv;

  // Entry payload: subtraction is A + ~B with carry-in 1.
  always_comb begin
    in_pl           = '0;
    in_pl.ctl.valid = in_valid;
    in_pl.ctl.sub   = in_sub;
`ifdef ADDER_SAT_EN
    in_pl.ctl.sat   = in_sat;
`else
    in_pl.ctl.sat   = 1'b0;
`endif
    in_pl.ctl.carry = in_sub;
    in_pl.a         = in_a;
    in_pl.b         = in_sub ? ~in_b : in_b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit IS_LAST = (k == STAGES - 1);
    payload_t      src;
    payload_t      nxt;
    logic [SW-1:0] slice_sum;
    logic          slice_cout;

    if (k == 0) begin : g_first
      assign src = in_pl;
    end else begin : g_rest
      assign src = stage_q[k-1];
    end

    adder_slice #(.W(SW)) u_slice (
      .a    (src.a[k*SW +: SW]),
      .b    (src.b[k*SW +: SW]),
      .cin  (src.ctl.carry),
      .sum  (slice_sum),
      .cout (slice_cout)
    );

    // Fill in this slice's sum bits; the final slice also applies saturation.
    always_comb begin
      nxt                 = src;
      nxt.sum[k*SW +: SW] = slice_sum;
      nxt.ctl.carry       = slice_cout;
      if (IS_LAST && src.ctl.sat) begin
        if (!src.ctl.sub && slice_cout) begin
          nxt.sum = '1;
        end else if (src.ctl.sub && !slice_cout) begin
          nxt.sum = '0;
        end
      end
    end

    assign stage_d[k] = adv ? nxt : stage_q[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign out_valid = stage_q[STAGES-1].ctl.valid;
  assign out_sum   = stage_q[STAGES-1].sum;
  assign out_carry = stage_q[STAGES-1].ctl.carry;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of pipelined_adder at WIDTH=8/STAGES=2 and at
// the default WIDTH=32/STAGES=4. Saturation vectors are included when ADDER_SAT_EN is defined.
module tb_pipelined_adder;

  logic       clk = 1'b0;
  logic       rst;
  // 8-bit / 2-stage instance
  logic       in_valid, in_sub, in_sat, out_ready;
  logic [7:0] in_a, in_b;
  logic       in_ready, out_valid, out_carry;
  logic [7:0] out_sum;
  // default-parameter instance
  logic        d_in_valid, d_in_sub, d_in_sat, d_out_ready;
  logic [31:0] d_in_a, d_in_b;
  logic        d_in_ready, d_out_valid, d_out_carry;
  logic [31:0] d_out_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
`ifdef ADDER_SAT_EN
    .in_sat(in_sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_carry(out_carry)
  );

  pipelined_adder u_def (
    .clk(clk), .rst(rst),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_a(d_in_a), .in_b(d_in_b), .in_sub(d_in_sub),
`ifdef ADDER_SAT_EN
    .in_sat(d_in_sat),
`endif
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_sum(d_out_sum), .out_carry(d_out_carry)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       sat;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Single isolated op through the 8-bit unit; checks latency, sum and carry.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_a = v.a; in_b = v.b; in_sub = v.sub; in_sat = v.sat; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("vec%0d_latency", idx), 32'(lat), 32'd2);
    chk($sformatf("vec%0d_sum", idx), 32'(out_sum), 32'(v.sum));
    chk($sformatf("vec%0d_carry", idx), 32'(out_carry), 32'(v.carry));
  endtask

  // Single isolated op through the default 32-bit, 4-stage unit.
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] sum, input logic carry, input string name);
    int lat;
    @(negedge clk);
    d_in_valid = 1'b1; d_in_a = a; d_in_b = b; d_in_sub = sub;
    @(negedge clk);
    d_in_valid = 1'b0;
    lat = 1;
    while (!d_out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_sum"}, d_out_sum, sum);
    chk({name, "_carry"}, 32'(d_out_carry), 32'(carry));
  endtask

  vec_t vecs [12];
  int   n_vec;

  logic [7:0] exp_sum [4];
  logic       exp_c   [4];
  logic [7:0] s_a [4];
  logic [7:0] s_b [4];
  logic       s_sub [4];

  initial begin
    // Directed vectors: {a, b, sub, sat, sum, carry}
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0};
    vecs[3] = '{8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0};
    n_vec = 8;
`ifdef ADDER_SAT_EN
    vecs[8]  = '{8'hF0, 8'h20, 1'b0, 1'b1, 8'hFF, 1'b1};
    vecs[9]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[10] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0};
    vecs[11] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1};
    n_vec = 12;
`endif

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_sat = 1'b0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_sub = 1'b0; d_in_sat = 1'b0; d_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_sum", 32'(out_sum), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_def_out_valid", 32'(d_out_valid), 32'd0);
    rst = 1'b0;

    // Async reset with two ops in flight and the head op blocked.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22; in_sub = 1'b0;
    @(negedge clk);
    in_a = 8'h33; in_b = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    chk("inflight_out_valid", 32'(out_valid), 32'd1);
    chk("inflight_out_sum", 32'(out_sum), 32'h33);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_sum", 32'(out_sum), 32'd0);
    chk("async_rst_out_carry", 32'(out_carry), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_no_stale%0d", i), 32'(out_valid), 32'd0);
    end

    for (int i = 0; i < n_vec; i++) run_vec(vecs[i], i);

    // Back-to-back stream of 4 ops with a 3-cycle output stall mid-stream.
    s_a[0] = 8'h10; s_b[0] = 8'h20; s_sub[0] = 1'b0; exp_sum[0] = 8'h30; exp_c[0] = 1'b0;
    s_a[1] = 8'hF0; s_b[1] = 8'h20; s_sub[1] = 1'b0; exp_sum[1] = 8'h10; exp_c[1] = 1'b1;
    s_a[2] = 8'h08; s_b[2] = 8'h03; s_sub[2] = 1'b1; exp_sum[2] = 8'h05; exp_c[2] = 1'b1;
    s_a[3] = 8'h03; s_b[3] = 8'h08; s_sub[3] = 1'b1; exp_sum[3] = 8'hFB; exp_c[3] = 1'b0;
    in_sat = 1'b0;
    begin
      int         sent;
      int         rcv;
      logic       held;
      logic [7:0] held_sum;
      logic       held_c;
      sent = 0; rcv = 0; held = 1'b0; held_sum = '0; held_c = 1'b0;
      for (int cyc = 0; cyc < 16; cyc++) begin
        @(negedge clk);
        if (held) begin
          chk($sformatf("stall_stable_sum_c%0d", cyc), 32'(out_sum), 32'(held_sum));
          chk($sformatf("stall_stable_carry_c%0d", cyc), 32'(out_carry), 32'(held_c));
        end
        out_ready = !(cyc >= 3 && cyc <= 5);
        if (sent < 4) begin
          in_valid = 1'b1; in_a = s_a[sent]; in_b = s_b[sent]; in_sub = s_sub[sent];
        end else begin
          in_valid = 1'b0;
        end
        #1;
        chk($sformatf("stream_in_ready_c%0d", cyc), 32'(in_ready), 32'(out_ready || !out_valid));
        if (out_valid && out_ready) begin
          if (rcv < 4) begin
            chk($sformatf("stream_sum%0d", rcv), 32'(out_sum), 32'(exp_sum[rcv]));
            chk($sformatf("stream_carry%0d", rcv), 32'(out_carry), 32'(exp_c[rcv]));
          end
          rcv++;
        end
        if (in_valid && (out_ready || !out_valid)) sent++;
        held = out_valid && !out_ready;
        held_sum = out_sum;
        held_c = out_carry;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream_results_count", 32'(rcv), 32'd4);
      chk("stream_sent_count", 32'(sent), 32'd4);
    end

    // Default configuration.
    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, "def_wrap");
    run32(32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, "def_borrow_chain");
    run32(32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b0, "def_neg");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
